// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, operand classes and classifier
package fpu_pkg;

  localparam int          FSQRT_LAT = 5;
  localparam logic [31:0] FP_QNAN   = 32'h7FC00000;
  localparam logic [31:0] FP_PINF   = 32'h7F800000;

  typedef enum logic [2:0] {
    NORMAL,
    ZERO,
    PINF,
    QNAN,
    SNAN,
    NEG
  } fp_cls_e;

  // NaN outranks sign; denormals collapse to zero before the sign test
  function automatic fp_cls_e fp_classify(input logic [31:0] x);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return x[22] ? QNAN : SNAN;
    if (x[30:23] == 8'h00) return ZERO;
    if (x[31]) return NEG;
    if (x[30:23] == 8'hFF) return PINF;
    return NORMAL;
  endfunction

endpackage

// File: rtl/fsqrt.sv
// rtl/fsqrt.sv - fixed-latency, non-stallable single-precision square root
// Result for input sampled in cycle N is on o_d during cycle N+FSQRT_LAT.
module fsqrt
  import fpu_pkg::*;
(
  input  logic        i_clk,
  input  logic [31:0] i_s,
  output logic [31:0] o_d
);

  function automatic logic [23:0] isqrt(input logic [49:0] r);
    logic [27:0] rem;
    logic [24:0] q;
    rem = '0;
    q   = '0;
    for (int i = 24; i >= 0; i--) begin
      rem = {rem[25:0], r[2*i +: 2]};
      if (rem >= {1'b0, q, 2'b01}) begin
        rem = rem - {1'b0, q, 2'b01};
        q   = {q[23:0], 1'b1};
      end else begin
        q   = {q[23:0], 1'b0};
      end
    end
    return q[23:0];
  endfunction

  logic [7:0]  w_e;
  logic [49:0] w_rad;
  logic [23:0] w_q;
  logic [23:0] w_frac;
  logic [7:0]  w_exp;
  logic [31:0] w_res;
  logic [31:0] r_d [FSQRT_LAT];

  assign w_e = i_s[30:23];
  // Even unbiased exponent (odd biased) keeps the mantissa; odd doubles it
  assign w_rad  = w_e[0] ? {1'b0, 1'b1, i_s[22:0], 25'b0} : {1'b1, i_s[22:0], 26'b0};
  assign w_q    = isqrt(w_rad);
  // Ties cannot occur for square roots, so the round bit alone decides
  assign w_frac = {1'b0, w_q[23:1]} + {23'd0, w_q[0]};
  assign w_exp  = {1'b0, w_e[7:1]} + 8'd63 + {7'd0, w_e[0]} + {7'd0, w_frac[23]};

  always_comb begin
    w_res = {1'b0, w_exp, w_frac[22:0]};
    if (i_s[31] || w_e == 8'h00) begin
      w_res = '0;
    end else if (w_e == 8'hFF) begin
      w_res = (i_s[22:0] == 23'd0) ? FP_PINF : FP_QNAN;
    end
  end

  always_ff @(posedge i_clk) begin
    r_d[0] <= w_res;
    for (int i = 1; i < FSQRT_LAT; i++) r_d[i] <= r_d[i-1];
  end

  assign o_d = r_d[FSQRT_LAT-1];

endmodule

// File: rtl/fsqrt_result_fifo.sv
// rtl/fsqrt_result_fifo.sv - circular result buffer with flush and registered head
module fsqrt_result_fifo #(
  parameter int DEPTH = 5,
  parameter int W     = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_empty,
  output logic [W-1:0] o_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;
  logic             w_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_pop) r_rd <= ptr_inc(r_rd);
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  overflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && w_full && !w_pop && !i_flush));

endmodule

// File: rtl/fsqrt_issue.sv
// rtl/fsqrt_issue.sv - credit-admitted issue/retire wrapper around fsqrt
// FSQRT_SPECIAL_EN: override results for zero/inf/NaN/negative operands and drive o_out_nv.
module fsqrt_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W = 6,
  parameter int DEPTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_src,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_data,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_out_nv
);

  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FSQRT_SPECIAL_EN
  localparam int FW = 33 + TAG_W;
`else
  localparam int FW = 32 + TAG_W;
`endif

  logic [CNT_W-1:0]     r_used;
  logic [FSQRT_LAT-1:0] r_vld;
  logic [TAG_W-1:0]     r_tag [FSQRT_LAT];
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_empty;
  logic [31:0]          w_sq_d;
  logic [FW-1:0]        w_push_data;
  logic [FW-1:0]        w_head;

  // Credits cover in-flight plus buffered results, so a retire always has room
  assign o_in_ready  = (r_used < CNT_W'(DEPTH)) && !i_flush;
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_valid = !w_empty;
  assign w_pop       = o_out_valid && i_out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld  <= '0;
      r_used <= '0;
    end else if (i_flush) begin
      r_vld  <= '0;
      r_used <= '0;
    end else begin
      r_vld <= {r_vld[FSQRT_LAT-2:0], w_accept};
      case ({w_accept, w_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    r_tag[0] <= i_in_tag;
    for (int i = 1; i < FSQRT_LAT; i++) r_tag[i] <= r_tag[i-1];
  end

  fsqrt u_fsqrt (
    .i_clk (i_clk),
    .i_s   (i_in_src),
    .o_d   (w_sq_d)
  );

`ifdef FSQRT_SPECIAL_EN
  fp_cls_e     r_cls [FSQRT_LAT];
  logic        r_sgn [FSQRT_LAT];
  logic [31:0] w_res;
  logic        w_nv;

  always_ff @(posedge i_clk) begin
    r_cls[0] <= fp_classify(i_in_src);
    r_sgn[0] <= i_in_src[31];
    for (int i = 1; i < FSQRT_LAT; i++) begin
      r_cls[i] <= r_cls[i-1];
      r_sgn[i] <= r_sgn[i-1];
    end
  end

  always_comb begin
    w_res = w_sq_d;
    w_nv  = 1'b0;
    case (r_cls[FSQRT_LAT-1])
      ZERO:    w_res = {r_sgn[FSQRT_LAT-1], 31'd0};
      PINF:    w_res = FP_PINF;
      QNAN:    w_res = FP_QNAN;
      SNAN: begin
        w_res = FP_QNAN;
        w_nv  = 1'b1;
      end
      NEG: begin
        w_res = FP_QNAN;
        w_nv  = 1'b1;
      end
      default: w_res = w_sq_d;
    endcase
  end

  assign w_push_data = {w_nv, w_res, r_tag[FSQRT_LAT-1]};
  assign o_out_nv    = w_head[FW-1];
`else
  assign w_push_data = {w_sq_d, r_tag[FSQRT_LAT-1]};
  assign o_out_nv    = 1'b0;
`endif

  fsqrt_result_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_push  (r_vld[FSQRT_LAT-1]),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_data  (w_head)
  );

  assign o_out_data = w_head[TAG_W +: 32];
  assign o_out_tag  = w_head[TAG_W-1:0];

endmodule
